// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit serializer.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   localparam int   DATA_BITS   = 8;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module baud_tick #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // With CLKS_PER_BIT=1 the count is pinned at 0, so every cycle is terminal.
   assign tick = (cnt_q == TERM);

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_out,
   output logic       busy,
   output logic       done
);

   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic                 tx_out_q, tx_out_d;
   logic                 done_q, done_d;
   logic                 tick;

   // Holding the counter clear while idle guarantees a full first bit period.
   baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk   (clk),
      .reset (reset),
      .clear (state_q == IDLE),
      .tick  (tick)
   );

   assign tx_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign tx_out   = tx_out_q;
   assign done     = done_q;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (tx_valid) begin
               shreg_d   = tx_data;
               bit_idx_d = '0;
               state_d   = START;
            end
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               shreg_d   = shreg_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is registered, so it is decoded from the next state.
      unique case (state_d)
         START:   tx_out_d = START_LEVEL;
         DATA:    tx_out_d = shreg_d[0];
         STOP:    tx_out_d = STOP_LEVEL;
         default: tx_out_d = IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_idx_q <= '0;
         tx_out_q  <= IDLE_LEVEL;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         tx_out_q  <= tx_out_d;
         done_q    <= done_d;
      end
   end

endmodule
